// File: rtl/bcd_sum_serializer.sv
// bcd_sum_serializer
// Captures a packed BCD sum plus the adder carry-out and streams it one BCD
// digit per valid/ready transfer, most-significant digit first. Leading zeros
// are skipped, while interior and trailing zeros are sent. Nibbles above 9 are
// flagged on digit_err and passed through unchanged. Only one result is held
// at a time, so upstream sees in_ready only while the block is idle.
module bcd_sum_serializer #(
    parameter int DIGITS = 100
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [4*DIGITS-1:0]   sum,
    input  logic                  cout,
    output logic                  digit_valid,
    input  logic                  digit_ready,
    output logic [3:0]            digit,
    output logic                  digit_last,
    output logic                  digit_err
);

    // The carry-out is stored as one extra top digit, so the value holds
    // DIGITS+1 digits and the index has to reach DIGITS.
    localparam int IW = $clog2(DIGITS + 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                 state;
    state_t                 state_nxt;

    logic [DIGITS:0][3:0]   value;      // captured digits, index DIGITS = carry
    logic [DIGITS:0][3:0]   value_in;   // incoming sum viewed as digits
    logic [IW-1:0]          index;      // digit currently on the output
    logic [IW-1:0]          msd;        // most-significant nonzero input digit
    logic [3:0]             cur;        // stored digit selected by index
    logic                   capture;
    logic                   xfer;

    assign capture = in_valid && (state == IDLE);
    assign xfer    = digit_valid && digit_ready;

    // Present the incoming sum and carry as DIGITS+1 BCD digits.
    always_comb begin
        value_in = '0;
        for (int i = 0; i < DIGITS; i++) begin
            value_in[i] = sum[4*i +: 4];
        end
        value_in[DIGITS] = {3'b000, cout};
    end

    // Leading-zero search on the incoming value: the highest nonzero digit
    // wins. Any nonzero nibble counts, including illegal ones above 9, so a
    // bad leading nibble is still emitted and flagged. An all-zero value
    // resolves to index 0, which emits a single 0 digit.
    always_comb begin
        msd = '0;
        for (int i = 0; i <= DIGITS; i++) begin
            if (value_in[i] != 4'd0) begin
                msd = IW'(i);
            end
        end
    end

    // Select the stored digit under the index. Written as an explicit
    // compare chain so index codes above DIGITS simply read as zero.
    always_comb begin
        cur = 4'd0;
        for (int i = 0; i <= DIGITS; i++) begin
            if (index == IW'(i)) begin
                cur = value[i];
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture moves to EMIT, the transfer of digit 0
    // returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (xfer && (index == '0)) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Data path: load the value and start index at capture, then walk the
    // index down one digit per transfer. The value is held untouched while
    // streaming, which keeps the outputs stable under backpressure.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            value <= '0;
            index <= '0;
        end else if (capture) begin
            value <= value_in;
            index <= msd;
        end else if (xfer && (index != '0)) begin
            index <= index - 1'b1;
        end
    end

    // Output decode: everything is zero in IDLE, so an asynchronous reset
    // drops digit_valid and the digit fields at once.
    always_comb begin
        in_ready    = 1'b0;
        digit_valid = 1'b0;
        digit       = 4'd0;
        digit_last  = 1'b0;
        digit_err   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
            end
            EMIT: begin
                digit_valid = 1'b1;
                digit       = cur;
                digit_last  = (index == '0);
                digit_err   = (cur > 4'd9);
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_bcd_sum_serializer.sv
// Directed bench for bcd_sum_serializer: a DIGITS=4 instance driven from a
// table of hand-computed digit streams plus a stall sequence, and a
// DIGITS=100 instance fed random legal BCD sums with random backpressure and
// a reset abort mid-stream, checked against a decimal digit model.
module tb_bcd_sum_serializer;

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    // DIGITS=4 instance
    logic         in_valid4, in_ready4, cout4;
    logic [15:0]  sum4;
    logic         dv4, dr4, dl4, de4;
    logic [3:0]   d4;

    // DIGITS=100 instance
    logic         in_valid100, in_ready100, cout100;
    logic [399:0] sum100;
    logic         dv100, dr100, dl100, de100;
    logic [3:0]   d100;

    int tests = 0;
    int fails = 0;

    bcd_sum_serializer #(.DIGITS(4)) dut4 (
        .clk(clk), .areset(areset),
        .in_valid(in_valid4), .in_ready(in_ready4),
        .sum(sum4), .cout(cout4),
        .digit_valid(dv4), .digit_ready(dr4),
        .digit(d4), .digit_last(dl4), .digit_err(de4)
    );

    bcd_sum_serializer #(.DIGITS(100)) dut100 (
        .clk(clk), .areset(areset),
        .in_valid(in_valid100), .in_ready(in_ready100),
        .sum(sum100), .cout(cout100),
        .digit_valid(dv100), .digit_ready(dr100),
        .digit(d100), .digit_last(dl100), .digit_err(de100)
    );

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        int          n;      // number of digits expected
        logic [19:0] dig;    // expected digits, first emitted in [19:16]
        logic [4:0]  err;    // err[k] = expected digit_err on k-th digit
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Capture one DIGITS=4 result and check its digit stream. The first
    // 'stall' cycles hold digit_ready low and wave a new in_valid, which must
    // neither advance nor disturb the stream.
    task automatic run4(input logic [15:0] s, input logic c, input int n,
                        input logic [19:0] dig, input logic [4:0] err, input int stall);
        int k;
        int st;
        @(negedge clk);
        chk("idle_in_ready", in_ready4, 1);
        chk("idle_valid", dv4, 0);
        in_valid4 = 1'b1;
        sum4      = s;
        cout4     = c;
        dr4       = 1'b1;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        sum4      = 16'h5555;
        cout4     = 1'b1;
        k  = 0;
        st = stall;
        while (k < n) begin
            @(negedge clk);
            chk("emit_valid", dv4, 1);
            chk("emit_in_ready", in_ready4, 0);
            chk("emit_digit", d4, dig[19-4*k -: 4]);
            chk("emit_last", dl4, (k == n-1) ? 1 : 0);
            chk("emit_err", de4, err[k]);
            if (st > 0) begin
                st--;
                dr4       = 1'b0;
                in_valid4 = 1'b1;
                sum4      = 16'h0999;
            end else begin
                dr4       = 1'b1;
                in_valid4 = 1'b0;
                k++;
            end
        end
        @(negedge clk);
        chk("done_valid", dv4, 0);
        chk("done_in_ready", in_ready4, 1);
    endtask

    // Random 100-digit result with digits above 'top' zero. If abort_at >= 0,
    // reset is pulsed when that many digits have been accepted.
    task automatic run100(input int top, input logic c, input int abort_at);
        logic [3:0] e[101];
        int msd;
        int n;
        int k;
        int cyc;
        for (int i = 0; i < 100; i++) begin
            if (i > top)       e[i] = 4'd0;
            else if (i == top) e[i] = 4'($urandom_range(1, 9));
            else               e[i] = 4'($urandom_range(0, 9));
        end
        e[100] = {3'b000, c};
        msd = 0;
        for (int i = 0; i <= 100; i++) if (e[i] != 4'd0) msd = i;
        n = msd + 1;
        @(negedge clk);
        chk("d100_idle_in_ready", in_ready100, 1);
        in_valid100 = 1'b1;
        cout100     = c;
        for (int i = 0; i < 100; i++) sum100[4*i +: 4] = e[i];
        @(posedge clk);
        #1;
        in_valid100 = 1'b0;
        sum100      = '0;
        cout100     = 1'b0;
        k   = 0;
        cyc = 0;
        while (k < n && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            dr100 = 1'($urandom_range(0, 1));
            chk("d100_valid", dv100, 1);
            chk("d100_digit", d100, e[msd-k]);
            chk("d100_last", dl100, (k == n-1) ? 1 : 0);
            chk("d100_err", de100, 0);
            if (abort_at >= 0 && k == abort_at) begin
                #2 areset = 1'b1;
                #1;
                chk("abort_valid", dv100, 0);
                chk("abort_in_ready", in_ready100, 1);
                chk("abort_digit", d100, 0);
                chk("abort_last", dl100, 0);
                @(negedge clk);
                areset = 1'b0;
                dr100  = 1'b0;
                return;
            end
            if (dr100) k++;
        end
        chk("d100_stream_complete", k, n);
        @(negedge clk);
        dr100 = 1'b0;
        chk("d100_done_valid", dv100, 0);
        chk("d100_done_in_ready", in_ready100, 1);
    endtask

    vec_t vecs[9];

    initial begin
        vecs[0] = '{16'h0305, 1'b0, 3, 20'h30500, 5'b00000};
        vecs[1] = '{16'h0000, 1'b0, 1, 20'h00000, 5'b00000};
        vecs[2] = '{16'h9999, 1'b1, 5, 20'h19999, 5'b00000};
        vecs[3] = '{16'h0A12, 1'b0, 3, 20'hA1200, 5'b00001};
        vecs[4] = '{16'h0007, 1'b1, 5, 20'h10007, 5'b00000};
        vecs[5] = '{16'h1000, 1'b0, 4, 20'h10000, 5'b00000};
        vecs[6] = '{16'h000F, 1'b0, 1, 20'hF0000, 5'b00001};
        vecs[7] = '{16'hB000, 1'b0, 4, 20'hB0000, 5'b00001};
        vecs[8] = '{16'h0120, 1'b0, 3, 20'h12000, 5'b00000};

        areset      = 1'b1;
        in_valid4   = 1'b0; sum4   = '0; cout4   = 1'b0; dr4   = 1'b0;
        in_valid100 = 1'b0; sum100 = '0; cout100 = 1'b0; dr100 = 1'b0;
        #12;
        chk("rst_in_ready", in_ready4, 1);
        chk("rst_valid", dv4, 0);
        chk("rst_digit", d4, 0);
        chk("rst_last", dl4, 0);
        chk("rst_err", de4, 0);
        chk("rst_in_ready100", in_ready100, 1);
        @(negedge clk);
        areset = 1'b0;

        // digit_ready while idle must not start anything
        dr4 = 1'b1;
        @(negedge clk);
        chk("idle_ready_no_effect", dv4, 0);

        for (int v = 0; v < 9; v++) begin
            run4(vecs[v].sum, vecs[v].cout, vecs[v].n, vecs[v].dig, vecs[v].err, 0);
        end

        // backpressure on the first digit, with in_valid waved during EMIT
        run4(16'h0042, 1'b0, 2, 20'h42000, 5'b00000, 3);
        // backpressure on a last-digit-only result
        run4(16'h0000, 1'b0, 1, 20'h00000, 5'b00000, 2);

        // 100-digit streams: abort mid-stream, then fresh results
        run100(90, 1'b0, 20);
        run100(97, 1'b0, -1);
        run100(40, 1'b1, -1);
        run100(0, 1'b0, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/bcd_sum_serializer.md
# bcd_sum_serializer

Downstream stage of the 100-digit BCD ripple-carry adder. Captures one packed BCD sum plus carry-out, suppresses leading zeros, and streams the result one BCD digit per transfer, most-significant first, over a valid/ready interface to display or transmit logic. One result is in flight at a time. Non-BCD nibbles are flagged, not corrected.

## Interface
- DIGITS, 100, number of BCD digits in the packed sum (≥2)
- clk  input  1  rising-edge clock
- areset  input  1  asynchronous active-high reset
- in_valid  input  1  sum/cout are valid this cycle
- in_ready  output  1  block can capture a result (high only in IDLE)
- sum  input  4*DIGITS  packed BCD sum, digit i at sum[4i+3:4i]
- cout  input  1  carry-out of the adder (acts as digit DIGITS)
- digit_valid  output  1  digit is valid
- digit_ready  input  1  consumer accepts digit
- digit  output  4  current BCD digit
- digit_last  output  1  current digit is the least-significant (index 0)
- digit_err  output  1  current digit nibble > 9

## Operation
- States: IDLE, EMIT.
- IDLE: in_ready=1, digit_valid=0. On in_valid&in_ready: register {cout, sum} as a DIGITS+1 digit value (cout as digit DIGITS = 4'd1 or 4'd0), load index with position of most-significant nonzero digit; if all digits and cout are zero, index=0. Go to EMIT.
- Leading-zero search is combinational on the input at capture; index register width clog2(DIGITS+1).
- EMIT: digit_valid=1, digit = stored digit[index], digit_last=(index==0), digit_err=(digit>9). Interior/trailing zeros are emitted; only leading zeros are skipped. A leading nibble >9 counts as nonzero.
- Transfer = digit_valid&digit_ready. On transfer with index>0: index−1, stay EMIT. On transfer with index==0: go IDLE.
- digit, digit_last, digit_err are stable while digit_valid&!digit_ready.
- in_valid in EMIT is ignored (in_ready=0); upstream must hold.
- sum/cout are not used after the capture cycle.

## Timing
- Reset values (areset high, effective immediately): state IDLE, in_ready=1, digit_valid=0, digit=0, digit_last=0, digit_err=0, index=0, stored value cleared.
- Capture at edge N → first digit valid in cycle N+1 (latency 1).
- With digit_ready held high, an n-digit result occupies n cycles of digit_valid; in_ready returns high the cycle after the last transfer (n+1 cycles per result, no back-to-back overlap).
- digit_ready high while digit_valid low has no effect.
- areset mid-EMIT aborts the stream: digit_valid drops asynchronously; no partial state survives; next capture starts fresh.

## Test plan
- DIGITS=4, sum=16'h0305, cout=0, digit_ready=1 → digits 3,0,5; digit_last only on 5; in_ready high the cycle after the 5.
- DIGITS=4, sum=16'h0000, cout=0 → single digit 0 with digit_last=1.
- DIGITS=4, sum=16'h9999, cout=1 → digits 1,9,9,9,9 (5 transfers).
- DIGITS=4, sum=16'h0042, digit_ready low 3 cycles on first digit → digit=4 held stable, no loss, then 4,2.
- DIGITS=4, sum=16'h0A12 → digits A(err=1),1(err=0),2(err=0).
- DIGITS=100 random legal BCD sums, random digit_ready; assert areset during EMIT → digit_valid=0 immediately, in_ready=1, next result streams correctly against a reference decimal model.
